// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer granting two requesters access to the shared ALU.
// Accept -> one-cycle EXEC -> RESP held until the granted requester consumes it.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_rs_i,
  input  logic [WIDTH-1:0] req0_rt_i,
  input  logic [OPW-1:0]   req0_opcode_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_rs_i,
  input  logic [WIDTH-1:0] req1_rt_i,
  input  logic [OPW-1:0]   req1_opcode_i,
  output logic             resp0_valid_o,
  input  logic             resp0_ready_i,
  output logic             resp1_valid_o,
  input  logic             resp1_ready_i,
  output logic [WIDTH-1:0] resp_result_o,
  output logic             resp_zero_o,
  output logic [WIDTH-1:0] alu_rs_o,
  output logic [WIDTH-1:0] alu_rt_o,
  output logic [OPW-1:0]   alu_opcode_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             win;
  logic             accept;
  logic             resp_done;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    win = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      win = ~last_grant;
    end else if (req1_valid_i) begin
      win = 1'b1;
    end
    accept    = (state == IDLE) && (req0_valid_i || req1_valid_i);
    resp_done = (state == RESP) && (grant ? resp1_ready_i : resp0_ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      op_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rs_q       <= win ? req1_rs_i     : req0_rs_i;
            rt_q       <= win ? req1_rt_i     : req0_rt_i;
            op_q       <= win ? req1_opcode_i : req0_opcode_i;
            grant      <= win;
            last_grant <= win;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result_i;
          zero_q   <= alu_zero_i;
          state    <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req0_ready_o  = accept && !win;
  assign req1_ready_o  = accept && win;
  assign resp0_valid_o = (state == RESP) && !grant;
  assign resp1_valid_o = (state == RESP) && grant;
  assign resp_result_o = result_q;
  assign resp_zero_o   = zero_q;
  assign busy_o        = (state != IDLE);

  // Operand registers are only exposed while an operation is in flight.
  assign alu_rs_o     = busy_o ? rs_q : '0;
  assign alu_rt_o     = busy_o ? rt_q : '0;
  assign alu_opcode_o = busy_o ? op_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in ALU (010 add, 100 sub).
module tb_alu_arbiter;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_rs, req0_rt, req1_rs, req1_rt;
  logic [OPW-1:0]   req0_opcode, req1_opcode;
  logic             resp0_valid, resp1_valid;
  logic             resp0_ready, resp1_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic [WIDTH-1:0] alu_rs, alu_rt;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_rs_i     (req0_rs),
    .req0_rt_i     (req0_rt),
    .req0_opcode_i (req0_opcode),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_rs_i     (req1_rs),
    .req1_rt_i     (req1_rt),
    .req1_opcode_i (req1_opcode),
    .resp0_valid_o (resp0_valid),
    .resp0_ready_i (resp0_ready),
    .resp1_valid_o (resp1_valid),
    .resp1_ready_i (resp1_ready),
    .resp_result_o (resp_result),
    .resp_zero_o   (resp_zero),
    .alu_rs_o      (alu_rs),
    .alu_rt_o      (alu_rt),
    .alu_opcode_o  (alu_opcode),
    .alu_result_i  (alu_result),
    .alu_zero_i    (alu_zero),
    .busy_o        (busy)
  );

  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b000:  alu_result = alu_rs & alu_rt;
      3'b001:  alu_result = alu_rs | alu_rt;
      3'b010:  alu_result = alu_rs + alu_rt;
      3'b100:  alu_result = alu_rs - alu_rt;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns -1 if no grant is seen within the cycle budget.
  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 8; i++) begin
      if (req0_ready) begin g = 0; break; end
      if (req1_ready) begin g = 1; break; end
      step();
    end
  endtask

  int g;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rs = '0; req0_rt = '0; req0_opcode = '0;
    req1_rs = '0; req1_rt = '0; req1_opcode = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    step();
    step();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    check("rst_result", resp_result, 0);
    check("rst_zero", resp_zero, 0);
    check("rst_alu_rs", alu_rs, 0);
    check("rst_alu_rt", alu_rt, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Single request from requester 0: 5 + 2
    req0_valid = 1'b1; req0_rs = 8'd5; req0_rt = 8'd2; req0_opcode = 3'b010;
    #1;
    check("single_ready0_N", req0_ready, 1);
    check("single_ready1_N", req1_ready, 0);
    check("single_busy_N", busy, 0);
    step();
    req0_valid = 1'b0;
    check("single_busy_N1", busy, 1);
    check("single_alu_rs", alu_rs, 5);
    check("single_alu_rt", alu_rt, 2);
    check("single_alu_op", alu_opcode, 3'b010);
    check("single_resp0_valid_N1", resp0_valid, 0);
    check("single_resp1_valid_N1", resp1_valid, 0);
    step();
    check("single_resp0_valid_N2", resp0_valid, 1);
    check("single_resp1_valid_N2", resp1_valid, 0);
    check("single_result", resp_result, 7);
    check("single_zero", resp_zero, 0);
    step();
    check("single_busy_N3", busy, 0);
    check("single_resp0_valid_N3", resp0_valid, 0);
    check("single_resp1_valid_N3", resp1_valid, 0);

    // Simultaneous requests right after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_rs = 8'd1;   req0_rt = 8'd1;   req0_opcode = 3'b010;
    req1_valid = 1'b1; req1_rs = 8'd255; req1_rt = 8'd255; req1_opcode = 3'b100;
    #1;
    wait_grant(g);
    check("sim_first_grant", g, 0);
    step();
    req0_valid = 1'b0;
    step();
    check("sim_resp0_valid", resp0_valid, 1);
    check("sim_result0", resp_result, 2);
    check("sim_zero0", resp_zero, 0);
    step();
    wait_grant(g);
    check("sim_second_grant", g, 1);
    step();
    req1_valid = 1'b0;
    step();
    check("sim_resp1_valid", resp1_valid, 1);
    check("sim_resp0_idle", resp0_valid, 0);
    check("sim_result1", resp_result, 0);
    check("sim_zero1", resp_zero, 1);
    step();

    // Fairness: both held valid for six operations
    req0_valid = 1'b1; req0_rs = 8'd3;  req0_rt = 8'd4; req0_opcode = 3'b010;
    req1_valid = 1'b1; req1_rs = 8'd20; req1_rt = 8'd5; req1_opcode = 3'b100;
    #1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(g);
      check("fair_grant", g, i % 2);
      step();
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      step();
      check("fair_result", resp_result, (i % 2 == 0) ? 7 : 15);
      check("fair_resp0_valid", resp0_valid, (i % 2 == 0) ? 1 : 0);
      check("fair_resp1_valid", resp1_valid, (i % 2 == 0) ? 0 : 1);
      step();
    end

    // Backpressure on requester 0 with requester 1 waiting
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_rs = 8'd5; req0_rt = 8'd2; req0_opcode = 3'b010;
    req1_valid = 1'b1; req1_rs = 8'd8; req1_rt = 8'd8; req1_opcode = 3'b100;
    #1;
    wait_grant(g);
    check("bp_grant", g, 0);
    step();
    req0_valid = 1'b0;
    step();
    check("bp_resp0_valid", resp0_valid, 1);
    check("bp_result", resp_result, 7);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_result", resp_result, 7);
      check("bp_hold_busy", busy, 1);
      check("bp_hold_ready1", req1_ready, 0);
      check("bp_hold_resp0_valid", resp0_valid, 1);
    end
    resp0_ready = 1'b1;
    #1;
    check("bp_handshake_ready1", req1_ready, 0);
    check("bp_handshake_busy", busy, 1);
    step();
    check("bp_after_busy", busy, 0);
    check("bp_after_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    check("rr_resp1_valid", resp1_valid, 1);
    check("rr_result", resp_result, 0);

    // Reset while the response to requester 1 is pending
    rst = 1'b1;
    step();
    check("rr_resp1_valid_after", resp1_valid, 0);
    check("rr_resp0_valid_after", resp0_valid, 0);
    check("rr_result_after", resp_result, 0);
    check("rr_zero_after", resp_zero, 0);
    check("rr_busy_after", busy, 0);
    check("rr_alu_rs_after", alu_rs, 0);
    check("rr_alu_rt_after", alu_rt, 0);
    check("rr_alu_op_after", alu_opcode, 0);
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rr_tie_ready0", req0_ready, 1);
    check("rr_tie_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("rr_tie_resp0_valid", resp0_valid, 1);
    step();

    // Idle period
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_ready0", req0_ready, 0);
      check("idle_ready1", req1_ready, 0);
      check("idle_alu_rs", alu_rs, 0);
      check("idle_alu_rt", alu_rt, 0);
      check("idle_alu_op", alu_opcode, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU (`rs`/`rt` operands, 3-bit opcode, 8-bit result, zero flag). It accepts operation requests from two independent masters over valid/ready handshakes, grants the ALU round-robin, registers operands, executes one operation, and returns the registered result and zero flag to the granted master. It sits between the control/datapath masters and the single `alu` instance, which it drives directly.

## Interface
- `WIDTH`, 8, operand/result width; must match the ALU.
- `OPW`, 3, opcode width.

Ports:
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req0_valid_i` / `req1_valid_i` in 1: requester n has an operation pending.
- `req0_ready_o` / `req1_ready_o` out 1: requester n's operation is accepted this cycle.
- `req0_rs_i`, `req0_rt_i` / `req1_rs_i`, `req1_rt_i` in WIDTH: operands.
- `req0_opcode_i` / `req1_opcode_i` in OPW: ALU opcode, passed through unmodified.
- `resp0_valid_o` / `resp1_valid_o` out 1: result for requester n is valid.
- `resp0_ready_i` / `resp1_ready_i` in 1: requester n consumes its response.
- `resp_result_o` out WIDTH: registered ALU result, shared by both response ports.
- `resp_zero_o` out 1: registered ALU zero flag.
- `alu_rs_o`, `alu_rt_o` out WIDTH; `alu_opcode_o` out OPW: drive the ALU.
- `alu_result_i` in WIDTH; `alu_zero_i` in 1: from the ALU (combinational).
- `busy_o` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `reqN_valid_i` is high, the arbiter picks a winner and asserts `reqN_ready_o` for that requester only, in the same cycle (combinational from valid and priority).
  - It then registers the winner's rs, rt and opcode plus a grant index, and moves to EXEC.
  - With no valid request it stays in IDLE.
- Round-robin priority:
  - A `last_grant` register resets to 1, so requester 0 wins the first tie.
  - When both requesters are valid, the one not equal to `last_grant` wins.
  - A single valid requester always wins.
  - `last_grant` updates only on an accepted request.
- EXEC, exactly one cycle:
  - `alu_*_o` carry the registered operands.
  - On the clock edge, `alu_result_i` → `resp_result_o` and `alu_zero_i` → `resp_zero_o`.
  - FSM moves to RESP.
- RESP:
  - `respN_valid_o` is high for the granted requester only.
  - Result and zero are held stable until `respN_ready_i` is high.
  - On that handshake, go to IDLE.
  - The other requester's `resp_ready` is ignored.
- `alu_*_o` hold their registered operands through EXEC and RESP. They are 0 in IDLE.
- Requests arriving while busy are not accepted: `ready` stays low and the requester must hold valid.
- ALU semantics are opaque. No opcode decoding.

## Timing
- Reset values:
  - All `ready_o` and `resp*_valid_o` are 0.
  - `resp_result_o`, `resp_zero_o`, `alu_*_o` and `busy_o` are 0.
  - FSM is IDLE; `last_grant` is 1.
- Latency:
  - Request accepted in cycle N.
  - EXEC in N+1.
  - `resp_valid` is high from N+2.
  - If `resp_ready` is high in N+2, the FSM is IDLE in N+3 and the next accept can occur in N+3.
  - Peak throughput is one operation per 3 cycles.
- `busy_o` is high from N+1 until the cycle the response handshake completes, inclusive.
- Backpressure: the response is held indefinitely. No timeout.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped, no response is issued, and all outputs return to reset values on the next edge.
- A requester deasserting valid in IDLE before it is granted is legal. No state is kept.

## Test plan
- Single request, requester 0: rs=5, rt=2, op=3'b010 (add) in cycle N. Required: `req0_ready_o`=1 in N, `resp0_valid_o`=1 at N+2 with `resp_result_o`=7, `resp_zero_o`=0, and `resp1_valid_o`=0 throughout.
- Simultaneous requests right after reset: req0 (op 3'b010, 1,1) and req1 (op 3'b100, 255,255) both held valid.
  - Requester 0 is granted first with result 2.
  - Requester 1 is granted at the first IDLE after that, with `resp_zero_o`=1.
- Fairness: both requesters held valid for 6 operations. Grants must alternate 0,1,0,1,0,1.
- Backpressure: hold `resp0_ready_i`=0 for 5 cycles with req1 valid.
  - `resp_result_o` stays stable and `busy_o` stays 1.
  - `req1_ready_o` stays 0 until the cycle after the response handshake.
- Reset in RESP: assert `rst_i` for one cycle while `resp1_valid_o`=1.
  - All outputs are 0 the next cycle.
  - The next tie goes to requester 0.
- Idle: no valids for 10 cycles. `busy_o`, all readys and `alu_*_o` stay 0.
